// File: rtl/seg_display_arbiter.sv
// Frame-synchronous arbiter and blanked scan driver for the shared 8-digit seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seg_display_arbiter #(
  parameter int CLK_DIV      = 500,
  parameter int BLANK_CYCLES = 4,
  parameter int HOLD_FRAMES  = 64
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg_req,
  input  logic [31:0] dbg_val,
  input  logic        mmio_req,
  input  logic [31:0] mmio_val,
  input  logic        uart_req,
  input  logic [31:0] uart_val,
  output logic [2:0]  grant,
  output logic [31:0] cur_val,
  output logic [7:0]  an,
  output logic [6:0]  sev_out,
  output logic        frame_start
);

  localparam int MAXC  = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int HLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [2:0] G_IDLE = 3'b000;
  localparam logic [2:0] G_DBG  = 3'b001;
  localparam logic [2:0] G_MMIO = 3'b010;
  localparam logic [2:0] G_UART = 3'b100;

  typedef enum logic {S_DIGIT, S_BLANK} state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         grant_q, grant_d;
  logic [31:0]        val_q, val_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         sev_q, sev_d;
  logic               fs_q, fs_d;
  logic [HLD_W-1:0]   hold_q, hold_d;
  logic               rr_q, rr_d;   // 0: mmio goes first, 1: uart goes first

  logic [2:0]         arb_grant;
  logic [31:0]        arb_val;
  logic               show;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [2:0] top_nibble(input logic [31:0] v);
    top_nibble = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) top_nibble = 3'(i);
    end
  endfunction
`endif

  // Arbitration decision, only committed at a frame boundary.
  always_comb begin
    arb_grant = G_IDLE;
    if (dbg_req) begin
      arb_grant = G_DBG;
    end else if (((grant_q == G_MMIO && mmio_req) || (grant_q == G_UART && uart_req)) &&
                 (hold_q < HLD_W'(HOLD_FRAMES))) begin
      arb_grant = grant_q;
    end else if (mmio_req && uart_req) begin
      arb_grant = rr_q ? G_UART : G_MMIO;
    end else if (mmio_req) begin
      arb_grant = G_MMIO;
    end else if (uart_req) begin
      arb_grant = G_UART;
    end
    case (arb_grant)
      G_DBG:   arb_val = dbg_val;
      G_MMIO:  arb_val = mmio_val;
      G_UART:  arb_val = uart_val;
      default: arb_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    val_d   = val_q;
    an_d    = an_q;
    sev_d   = sev_q;
    fs_d    = 1'b0;
    hold_d  = hold_q;
    rr_d    = rr_q;
    show    = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = S_DIGIT;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            fs_d    = 1'b1;
            grant_d = arb_grant;
            val_d   = arb_val;
            if (arb_grant == grant_q)
              hold_d = (hold_q < HLD_W'(HOLD_FRAMES)) ? hold_q + 1'b1 : hold_q;
            else
              hold_d = HLD_W'(1);
            if (arb_grant == G_MMIO) rr_d = 1'b1;
            if (arb_grant == G_UART) rr_d = 1'b0;
          end
          // Outputs for the new digit are registered on the entry edge.
          show = (grant_d != G_IDLE);
`ifdef LEADING_ZERO_BLANK_EN
          if (idx_d > top_nibble(val_d)) show = 1'b0;
`endif
          if (show) begin
            an_d  = ~(8'b1 << idx_d);
            sev_d = decode(val_d[{idx_d, 2'b00} +: 4]);
          end else begin
            an_d  = 8'hFF;
            sev_d = 7'h7F;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          an_d    = 8'hFF;
          sev_d   = 7'h7F;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_BLANK;
      idx_q   <= 3'd7;
      cnt_q   <= '0;
      grant_q <= G_IDLE;
      val_q   <= 32'h0;
      an_q    <= 8'hFF;
      sev_q   <= 7'h7F;
      fs_q    <= 1'b0;
      hold_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      val_q   <= val_d;
      an_q    <= an_d;
      sev_q   <= sev_d;
      fs_q    <= fs_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
    end
  end

  assign grant       = grant_q;
  assign cur_val     = val_q;
  assign an          = an_q;
  assign sev_out     = sev_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the 8-digit seven-segment display between three requesters: core debug/prog output, MMIO display register, and UART programming status. It arbitrates at frame boundaries and snapshots the granted 32-bit value. It then scans the digits with an inter-digit blanking gap to suppress ghosting. It sits between the core/memory controller/UART and the board pins, replacing the free-running anode scan.

Parameters:
CLK_DIV, 500, clk cycles each digit is driven (digit phase length)
BLANK_CYCLES, 4, clk cycles all anodes are off between digits
HOLD_FRAMES, 64, minimum frames a non-debug source keeps the display before round-robin may switch

Ports:
clk  in  1  system clock
Rst  in  1  synchronous active-high reset
dbg_req  in  1  debug/prog source requests display (highest priority)
dbg_val  in  32  debug value
mmio_req  in  1  MMIO display request
mmio_val  in  32  MMIO value
uart_req  in  1  UART status request
uart_val  in  32  UART status value
grant  out  3  one-hot current owner {uart,mmio,dbg}; 3'b000 = idle
cur_val  out  32  snapshot being displayed
an  out  8  anodes, active-low one-hot
sev_out  out  7  segments a..g, active-low, MSB = a
frame_start  out  1  one-cycle pulse when digit 0 phase begins

Behaviour:
- Reset: clk is clk; Rst is synchronous, active-high. All state resets on the next edge, including mid-frame.
- Reset values: state S_BLANK; digit index 7; prescale count 0; grant 3'b000; cur_val 0; an 8'hFF; sev_out 7'h7F; frame_start 0; hold count 0; round-robin pointer selects mmio first.
- Scan FSM has two states, S_DIGIT and S_BLANK.
  - S_BLANK lasts BLANK_CYCLES clocks with an = 8'hFF and sev_out = 7'h7F. It then enters S_DIGIT with idx = (idx+1) mod 8.
  - S_DIGIT lasts CLK_DIV clocks and drives an[idx] = 0 with sev_out = decode(cur_val[4*idx+3:4*idx]). It then enters S_BLANK.
  - Frame length = 8*(CLK_DIV+BLANK_CYCLES) clocks. The first digit after reset is digit 0, after BLANK_CYCLES clocks.
- Frame boundary is the S_BLANK->S_DIGIT transition into idx 0. On that edge, in the same cycle:
  - arbitrate, update grant and cur_val (cur_val = selected val, or 0 if idle);
  - pulse frame_start for the first cycle of the digit-0 phase.
- Arbitration at a boundary, in priority order:
  1. dbg_req=1 -> grant dbg. This preempts regardless of hold count.
  2. Owner is mmio or uart, its req is still 1, and hold < HOLD_FRAMES -> keep owner.
  3. Otherwise round-robin between mmio and uart, starting at the source after the last granted non-debug source; a single requester wins.
  4. No requests -> idle.
- Hold count:
  - Set to 1 on any change of owner.
  - Incremented on a kept frame, saturating at HOLD_FRAMES.
  - Dbg grants do not update the round-robin pointer.
- Request and value changes mid-frame are ignored until the next boundary; no tearing.
- Idle (grant 000): digit phases keep an = 8'hFF. The timing and FSM keep running.
- Decode table, hex -> sev_out: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, B 1100000, C 0110001, D 1000010, E 0110000, F 0111000.
- Outputs are registered; an and sev_out change on the same edge.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during S_DIGIT, any digit idx above the highest nonzero nibble of cur_val is blanked (an = 8'hFF, sev_out = 7'h7F). Digit 0 is always shown, so cur_val = 0 shows a single "0". Digit timing is unchanged.
- Undefined: all 8 digits are always shown.

Test Plan:
All scenarios use CLK_DIV=4, BLANK_CYCLES=2, HOLD_FRAMES=2 (frame = 48 clocks).
1. Reset, then mmio_req=1, mmio_val=32'h0000_00A1 -> first frame_start 2 clocks after reset release; grant=010. Digit 0: an=FE, sev=1001111 for 4 clocks, then an=FF for 2 clocks. Digit 1: an=FD, sev=0001000.
2. mmio owning, mmio_val changed mid-frame to 32'h1 -> cur_val holds the old value until the next frame_start, then becomes 1.
3. mmio and uart both requesting from reset -> grants mmio, mmio, uart, uart, mmio across successive frames (hold=2 round-robin).
4. uart owning, dbg_req=1 asserted mid-frame with dbg_val=32'hDEAD_BEEF -> grant=001 at the next boundary; digit 7 shows D (1000010). After dbg_req drops, round-robin resumes with mmio if it is requesting.
5. All reqs low -> grant=000, cur_val=0, an stays FF through a full frame while frame_start still pulses every 48 clocks.
6. Rst asserted mid digit 3 -> next edge gives an=FF, sev=7F, grant=000; the scan restarts at digit 0. With LEADING_ZERO_BLANK_EN and cur_val=32'h0000_0120, only digits 0-2 light.
